spu_gen2: RTL and testbench

Parametrised second-generation single-purpose processor core. It merges controller, 16-entry register file and ALU into one block that is configurable in data width and memory address widths. Compared with the first-generation SPU it adds logic/shift ops, unconditional jump, HALT with restart, and illegal-opcode trapping. It sits between a synchronous instruction memory (16-bit words) and a synchronous data memory.

---
 rtl/spu_gen2.sv | 167 ++++++++++++++++
 tb/tb_spu_gen2.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_gen2.sv
// Single-purpose processor core: fetch/decode/execute controller, 16-entry register file and ALU
// between a synchronous 16-bit instruction memory and a synchronous data memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_FETCH  | im_rd high, im_addr = pc
// S_DECODE | instruction word arrives, captured into ir, pc advances
// S_EXEC   | ALU write-back, store, load request, jumps, halt/trap
// S_LOADWB | load data arrives and is written to Ra
// S_HALT   | stopped after HALT or an undefined opcode, waiting for start
module spu_gen2 #(
    parameter int DW    = 16,
    parameter int IM_AW = 8,
    parameter int DM_AW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             stop,
    output logic             illegal,
    input  logic [15:0]      im_r_data,
    output logic [IM_AW-1:0] im_addr,
    output logic             im_rd,
    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_rd,
    output logic             dm_wr,
    input  logic [DW-1:0]    dm_r_data,
    output logic [DW-1:0]    dm_w_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_LOADWB, S_HALT
    } state_t;

    state_t           state, state_nxt;
    logic [IM_AW-1:0] pc, pc_nxt;
    logic [15:0]      ir, ir_nxt;
    logic             illegal_nxt;
    logic [DW-1:0]    rf [16];

    logic             rf_we;
    logic [DW-1:0]    rf_wd;
    logic [DW-1:0]    alu_res;

    logic [3:0]       op, ra, rb, rc;
    logic [7:0]       k;
    logic [DW-1:0]    val_a, val_b, val_c;
    logic [DW-1:0]    k_dw;
    logic [IM_AW-1:0] pc_off;
    logic [IM_AW-1:0] pc_target;
    logic             rc_ge_dw;

    assign op = ir[15:12];
    assign ra = ir[11:8];
    assign rb = ir[7:4];
    assign rc = ir[3:0];
    assign k  = ir[7:0];

    assign val_a = rf[ra];
    assign val_b = rf[rb];
    assign val_c = rf[rc];

    assign k_dw     = DW'($signed(k));
    assign pc_off   = IM_AW'($signed(k));
    assign rc_ge_dw = int'(rc) >= DW;

    // pc already points past the jump when it executes, so step back one for the base
    assign pc_target = pc + pc_off - {{(IM_AW-1){1'b0}}, 1'b1};

    assign im_addr = pc;

    always_comb begin
        alu_res = '0;
        case (op)
            4'h2:    alu_res = val_b + val_c;
            4'h3:    alu_res = k_dw;
            4'h4:    alu_res = val_b - val_c;
            4'h6:    alu_res = val_b & val_c;
            4'h7:    alu_res = val_b | val_c;
            4'h8:    alu_res = val_b ^ val_c;
            4'hA:    alu_res = rc_ge_dw ? '0 : (val_b << rc);
            4'hB:    alu_res = rc_ge_dw ? '0 : (val_b >> rc);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            illegal <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ir      <= ir_nxt;
            illegal <= illegal_nxt;
            if (rf_we) rf[ra] <= rf_wd;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        illegal_nxt = illegal;
        rf_we       = 1'b0;
        rf_wd       = alu_res;
        stop        = 1'b0;
        im_rd       = 1'b0;
        dm_rd       = 1'b0;
        dm_wr       = 1'b0;
        dm_addr     = '0;
        dm_w_data   = '0;
        case (state)
            S_IDLE, S_HALT: begin
                stop = 1'b1;
                if (start) begin
                    state_nxt   = S_FETCH;
                    pc_nxt      = '0;
                    illegal_nxt = 1'b0;
                end
            end
            S_FETCH: begin
                im_rd     = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ir_nxt    = im_r_data;
                pc_nxt    = pc + {{(IM_AW-1){1'b0}}, 1'b1};
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (op)
                    4'h0: begin
                        dm_rd     = 1'b1;
                        dm_addr   = ir[DM_AW-1:0];
                        state_nxt = S_LOADWB;
                    end
                    4'h1: begin
                        dm_wr     = 1'b1;
                        dm_addr   = ir[DM_AW-1:0];
                        dm_w_data = val_a;
                    end
                    4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB: rf_we = 1'b1;
                    4'h5: if (val_a == '0) pc_nxt = pc_target;
                    4'h9: pc_nxt = pc_target;
                    4'hF: state_nxt = S_HALT;
                    default: begin
                        illegal_nxt = 1'b1;
                        state_nxt   = S_HALT;
                    end
                endcase
            end
            S_LOADWB: begin
                rf_we     = 1'b1;
                rf_wd     = dm_r_data;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spu_gen2.sv
// Directed bench for spu_gen2: a DW=16 core and a DW=8 core, each with behavioural
// synchronous instruction/data memories; register contents are observed through STOREs.
module tb_spu_gen2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start8;
    logic        stop, illegal, im_rd, dm_rd, dm_wr;
    logic [15:0] im_r_data, dm_r_data, dm_w_data;
    logic [7:0]  im_addr, dm_addr;

    logic        stop8, illegal8, im_rd8, dm_rd8, dm_wr8;
    logic [15:0] im_r_data8;
    logic [7:0]  dm_r_data8, dm_w_data8;
    logic [7:0]  im_addr8;
    logic [3:0]  dm_addr8;

    logic [15:0] im  [256];
    logic [15:0] dm  [256];
    logic [15:0] im8 [256];
    logic [7:0]  dm8 [16];

    logic        pl_en = 1'b0, pl8_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    int n_pass = 0, n_fail = 0, n_total = 0;
    int excl_bad = 0;
    int cyc, nf, nwr;
    logic [31:0] imask;
    logic [15:0] fa [16];
    logic [15:0] wr_addr, wr_data;
    logic        stop_at1, ill_at1;

    spu_gen2 #(.DW(16), .IM_AW(8), .DM_AW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .illegal(illegal),
        .im_r_data(im_r_data), .im_addr(im_addr), .im_rd(im_rd),
        .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .dm_r_data(dm_r_data), .dm_w_data(dm_w_data)
    );

    spu_gen2 #(.DW(8), .IM_AW(8), .DM_AW(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .stop(stop8), .illegal(illegal8),
        .im_r_data(im_r_data8), .im_addr(im_addr8), .im_rd(im_rd8),
        .dm_addr(dm_addr8), .dm_rd(dm_rd8), .dm_wr(dm_wr8),
        .dm_r_data(dm_r_data8), .dm_w_data(dm_w_data8)
    );

    always @(posedge clk) begin
        if (im_rd)  im_r_data  <= im[im_addr];
        if (im_rd8) im_r_data8 <= im8[im_addr8];
    end

    always @(posedge clk) begin
        if (pl_en)      dm[pl_addr] <= pl_data;
        else if (dm_wr) dm[dm_addr] <= dm_w_data;
        if (dm_rd)      dm_r_data   <= dm[dm_addr];
        if (pl8_en)      dm8[pl_addr[3:0]] <= pl_data[7:0];
        else if (dm_wr8) dm8[dm_addr8]     <= dm_w_data8;
        if (dm_rd8)      dm_r_data8        <= dm8[dm_addr8];
    end

    always @(negedge clk) begin
        if (32'(im_rd) + 32'(dm_rd) + 32'(dm_wr) > 1) excl_bad++;
        if (32'(im_rd8) + 32'(dm_rd8) + 32'(dm_wr8) > 1) excl_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pdm(input logic [7:0] a, input logic [15:0] d, input bit narrow);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        if (narrow) pl8_en = 1'b1; else pl_en = 1'b1;
        @(negedge clk);
        pl_en  = 1'b0;
        pl8_en = 1'b0;
    endtask

    // Start the wide core and trace it until stop; cyc ends as the first cycle with stop=1
    // (cycle 1 is the first cycle after start is sampled). start is re-pulsed at cycle poke.
    task automatic run(input int poke);
        nf = 0; nwr = 0; imask = '0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 16; i++) fa[i] = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        stop_at1 = stop;
        ill_at1  = illegal;
        while (stop !== 1'b1 && cyc < 500) begin
            if (im_rd) begin
                if (nf < 16) fa[nf] = 16'(im_addr);
                nf++;
                if (cyc < 32) imask[cyc] = 1'b1;
            end
            if (dm_wr) begin
                nwr++;
                wr_addr = 16'(dm_addr);
                wr_data = dm_w_data;
            end
            start = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start8 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            im[i]  = 16'hF000;
            im8[i] = 16'hF000;
        end
        repeat (3) @(negedge clk);
        check("rst_stop",    32'(stop), 1);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_strobes", {29'd0, im_rd, dm_rd, dm_wr}, 0);
        check("rst_addrs",   {16'(im_addr), 16'(dm_addr)}, 0);
        check("rst_wdata",   32'(dm_w_data), 0);
        rst = 1'b1;
        @(negedge clk);

        // MOVI sign extension, HALT timing
        im[0] = 16'h3180; im[1] = 16'hF000;
        run(0);
        check("movi_stop_cyc", cyc, 7);
        check("movi_stop_c1",  32'(stop_at1), 0);
        check("movi_im_rd",    imask, 32'h12);
        check("movi_illegal",  32'(illegal), 0);
        im[0] = 16'h110A;
        run(0);
        check("movi_r1",  32'(dm[10]), 32'hFF80);
        check("movi_nwr", nwr, 1);

        // LOAD/ADD/STORE with a start pulse during execution
        pdm(8'd5, 16'd7, 1'b0);
        pdm(8'd6, 16'd9, 1'b0);
        pdm(8'd9, 16'hAAAA, 1'b0);
        im[0] = 16'h0005; im[1] = 16'h0106; im[2] = 16'h2201; im[3] = 16'h1209; im[4] = 16'hF000;
        run(8);
        check("las_stop_cyc", cyc, 18);
        check("las_dm9",      32'(dm[9]), 16);
        check("las_nwr",      nwr, 1);
        check("las_wr_addr",  32'(wr_addr), 9);
        check("las_wr_data",  32'(wr_data), 16);

        // JMPZ taken with wrap, then not taken
        im[0] = 16'h53FF; im[1] = 16'hF000; im[255] = 16'hF000;
        run(0);
        check("jmpz_t_fetch", 32'(fa[1]), 32'hFF);
        check("jmpz_t_cyc",   cyc, 7);
        im[0] = 16'h3301;
        run(0);
        im[0] = 16'h53FF;
        run(0);
        check("jmpz_nt_fetch", 32'(fa[1]), 1);
        check("jmpz_nt_cyc",   cyc, 7);

        // Arithmetic/logic edges and JMP skip
        for (int a = 20; a < 28; a++) pdm(8'(a), 16'hAAAA, 1'b0);
        im[0]  = 16'h34FF; im[1]  = 16'h3501; im[2]  = 16'h2645; im[3]  = 16'h3700;
        im[4]  = 16'h4875; im[5]  = 16'hAA5F; im[6]  = 16'hBBA4; im[7]  = 16'h7CAB;
        im[8]  = 16'h8DC4; im[9]  = 16'h6ED4; im[10] = 16'h1614; im[11] = 16'h1815;
        im[12] = 16'h1A16; im[13] = 16'h1B17; im[14] = 16'h1C18; im[15] = 16'h1D19;
        im[16] = 16'h1E1A; im[17] = 16'h9002; im[18] = 16'h3655; im[19] = 16'h161B;
        im[20] = 16'hF000;
        run(10);
        check("alu_stop_cyc", cyc, 61);
        check("alu_nwr",      nwr, 8);
        check("add_wrap",     32'(dm[20]), 0);
        check("sub_wrap",     32'(dm[21]), 32'hFFFF);
        check("shl_15",       32'(dm[22]), 32'h8000);
        check("shr_4",        32'(dm[23]), 32'h0800);
        check("or",           32'(dm[24]), 32'h8800);
        check("xor",          32'(dm[25]), 32'h77FF);
        check("and",          32'(dm[26]), 32'h77FF);
        check("jmp_skip",     32'(dm[27]), 0);

        // Undefined opcode trap and restart
        pdm(8'd30, 16'hAAAA, 1'b0);
        pdm(8'd31, 16'hAAAA, 1'b0);
        for (int i = 0; i < 21; i++) im[i] = 16'hF000;
        im[0] = 16'h3203; im[1] = 16'h121E; im[2] = 16'hD21E; im[3] = 16'h131F;
        run(0);
        check("ill_stop_cyc", cyc, 10);
        check("ill_flag",     32'(illegal), 1);
        check("ill_nwr",      nwr, 1);
        check("ill_dm30",     32'(dm[30]), 3);
        check("ill_dm31",     32'(dm[31]), 32'hAAAA);
        repeat (3) @(negedge clk);
        check("ill_sticky", {30'd0, stop, illegal}, 3);
        im[0] = 16'h121F; im[1] = 16'hF000; im[2] = 16'hF000; im[3] = 16'hF000;
        run(0);
        check("ill_clr_c1",  32'(ill_at1), 0);
        check("ill_restart", 32'(fa[0]), 0);
        check("ill_r2_kept", 32'(dm[31]), 3);
        check("ill_clr_end", 32'(illegal), 0);

        // Reset during LOADWB, with start asserted alongside reset
        pdm(8'd40, 16'h1234, 1'b0);
        pdm(8'd41, 16'hAAAA, 1'b0);
        im[0] = 16'h0528; im[1] = 16'hF000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rl_exec_dm_rd", 32'(dm_rd), 1);
        @(negedge clk);
        rst = 1'b0; start = 1'b1;
        @(negedge clk);
        check("rl_stop",    32'(stop), 1);
        check("rl_strobes", {29'd0, im_rd, dm_rd, dm_wr}, 0);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rl_idle", {31'd0, stop}, 1);
        im[0] = 16'h1529;
        run(0);
        check("rl_r5", 32'(dm[41]), 0);

        // DW=8 core: shift amounts at and beyond the width
        for (int a = 3; a < 6; a++) pdm(8'(a), 16'h00AA, 1'b1);
        im8[0] = 16'h317F; im8[1] = 16'hB219; im8[2] = 16'h1203; im8[3] = 16'hA311;
        im8[4] = 16'h1304; im8[5] = 16'hA418; im8[6] = 16'h1405; im8[7] = 16'hF000;
        @(negedge clk) start8 = 1'b1;
        @(negedge clk) start8 = 1'b0;
        cyc = 1;
        while (stop8 !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("dw8_stop_cyc", cyc, 25);
        check("dw8_shr_9",    32'(dm8[3]), 0);
        check("dw8_shl_1",    32'(dm8[4]), 32'hFE);
        check("dw8_shl_8",    32'(dm8[5]), 0);

        check("strobe_excl", excl_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
